uart_rx_fifo: RTL and testbench

Byte buffer placed directly downstream of the UART receiver. It captures every byte presented with a one-cycle write strobe, driven by the receiver's done pulse and data bus. It holds up to DEPTH bytes and presents them first-word-fall-through on a valid/ready read port to the consumer logic. Bytes arriving while the buffer is full are dropped and flagged, so the receiver never stalls.

---
 rtl/uart_pkg.sv | 16 +
 rtl/fifo_regfile.sv | 26 ++
 rtl/uart_rx_fifo.sv | 124 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and helpers.
package uart_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x DATA_W storage array: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fifo_regfile #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte buffer behind the UART receiver; drops on full.
// Define UART_RX_FIFO_OVF_CNT_EN to add the saturating ovf_cnt drop counter.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_W = UART_DATA_W,
    parameter  int DEPTH  = UART_RX_FIFO_DEPTH,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
`ifdef UART_RX_FIFO_OVF_CNT_EN
    output logic [7:0]        ovf_cnt,
`endif
    input  logic              ovf_clr
);

    localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              rd_fire, wr_acc, drop;
    logic [DATA_W-1:0] rf_rdata;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign rd_valid = !empty;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign rd_data  = empty ? '0 : rf_rdata;

    assign rd_fire = rd_valid && rd_ready;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_acc  = wr_en && (!full || rd_fire);
    assign drop    = wr_en && !wr_acc;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + ONE;
        end
        if (wr_acc && !rd_fire) begin
            count_d = count_q + ONE;
        end else if (rd_fire && !wr_acc) begin
            count_d = count_q - ONE;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef UART_RX_FIFO_OVF_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (drop && ovf_clr) begin
            ovf_cnt_d = 8'd1;
        end else if (drop) begin
            ovf_cnt_d = (ovf_cnt_q == 8'hFF) ? 8'hFF : ovf_cnt_q + 8'd1;
        end else if (ovf_clr) begin
            ovf_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt_q <= 8'd0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

    fifo_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (rf_rdata)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo (queue model of accepted bytes).
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       ovf_clr;
`ifdef UART_RX_FIFO_OVF_CNT_EN
    logic [7:0] ovf_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb_q [$];
    logic       m_ovf;
    logic [7:0] m_cnt;

    always #10 clk = ~clk;

    uart_rx_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
`ifdef UART_RX_FIFO_OVF_CNT_EN
        .ovf_cnt  (ovf_cnt),
`endif
        .ovf_clr  (ovf_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state();
        int n;
        n = sb_q.size();
        check("count", 32'(count), 32'(n));
        check("empty", 32'(empty), 32'(n == 0));
        check("full", 32'(full), 32'(n == DEPTH));
        check("rd_valid", 32'(rd_valid), 32'(n != 0));
        check("rd_data", 32'(rd_data), (n == 0) ? 32'd0 : 32'(sb_q[0]));
        check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef UART_RX_FIFO_OVF_CNT_EN
        check("ovf_cnt", 32'(ovf_cnt), 32'(m_cnt));
`endif
    endtask

    task automatic step(input logic w, input logic [7:0] d,
                        input logic r, input logic clr);
        logic fire, acc, drop;
        @(negedge clk);
        wr_en    = w;
        wr_data  = d;
        rd_ready = r;
        ovf_clr  = clr;
        fire = (sb_q.size() != 0) && r;
        acc  = w && ((sb_q.size() < DEPTH) || fire);
        drop = w && !acc;
        if (fire) begin
            check("rd_pop", 32'(rd_data), 32'(sb_q[0]));
            void'(sb_q.pop_front());
        end
        if (acc) sb_q.push_back(d);
        if (drop && clr) m_cnt = 8'd1;
        else if (drop) m_cnt = (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1;
        else if (clr) m_cnt = 8'd0;
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(posedge clk);
        #1;
        wr_en    = 1'b0;
        rd_ready = 1'b0;
        ovf_clr  = 1'b0;
        chk_state();
    endtask

    task automatic drain();
        while (sb_q.size() != 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic fill();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        rd_ready = 1'b0;
        ovf_clr  = 1'b0;
        m_ovf    = 1'b0;
        m_cnt    = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_state();
        @(negedge clk);
        rst = 1'b0;

        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        drain();

        fill();
        step(1'b1, 8'h55, 1'b0, 1'b0);
        drain();

        fill();
        step(1'b1, 8'h77, 1'b1, 1'b0);
        drain();

        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
            check("cnt_le1", 32'(count <= 5'd1), 32'd1);
        end
        drain();

        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        sb_q.delete();
        m_ovf = 1'b0;
        m_cnt = 8'd0;
        chk_state();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        drain();

        fill();
        step(1'b1, 8'hE1, 1'b0, 1'b0);
        step(1'b1, 8'hE2, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'hE3, 1'b0, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
